// File: rtl/route_table_lookup_pkg.sv
// Shared types and sizing for the routing-table lookup block.
// Optional statistics are enabled with ROUTE_LOOKUP_STATS_EN.
package route_table_lookup_pkg;

    localparam int ROUTING_TABLE_WORD_WIDTH = 32;
    localparam int ROUTING_TABLE_WORD_BITS  = 2;
    localparam int CONN_ID_WIDTH            = 4;
    localparam int DEVICE_ID_WIDTH          = 10;
    localparam int TAG_WIDTH                = 8;

    localparam int ENTRIES_PER_WORD = ROUTING_TABLE_WORD_WIDTH / CONN_ID_WIDTH;
    localparam int TABLE_WORDS      = 2 ** ROUTING_TABLE_WORD_BITS;
    localparam int TABLE_ENTRIES    = TABLE_WORDS * ENTRIES_PER_WORD;
    localparam int ENTRY_BITS       = $clog2(TABLE_ENTRIES);
    localparam int LANE_BITS        = $clog2(ENTRIES_PER_WORD);
    localparam int LSB_BITS         = $clog2(ROUTING_TABLE_WORD_WIDTH);

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        ARMED
    } rtl_state_t;

    typedef struct packed {
        logic [CONN_ID_WIDTH-1:0] conn_id;
        logic                     is_local;
        logic                     miss;
        logic [TAG_WIDTH-1:0]     tag;
    } lookup_t;

    // Local beats miss; a miss never reports a table entry.
    function automatic lookup_t resolve(
        input logic [DEVICE_ID_WIDTH-1:0] dest,
        input logic [DEVICE_ID_WIDTH-1:0] self_id,
        input logic [CONN_ID_WIDTH-1:0]   entry,
        input logic [TAG_WIDTH-1:0]       tag
    );
        lookup_t r;
        r     = '0;
        r.tag = tag;
        if (dest == self_id) begin
            r.is_local = 1'b1;
        end else if (dest >= DEVICE_ID_WIDTH'(TABLE_ENTRIES)) begin
            r.miss = 1'b1;
        end else begin
            r.conn_id = entry;
        end
        return r;
    endfunction

endpackage

// File: rtl/route_table_regfile.sv
// Routing table storage: one synchronous word write port,
// one combinational per-entry read port.
module route_table_regfile
    import route_table_lookup_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [ROUTING_TABLE_WORD_BITS-1:0]  wr_addr,
    input  logic [ROUTING_TABLE_WORD_WIDTH-1:0] wr_data,
    input  logic [ENTRY_BITS-1:0]               rd_entry,
    output logic [CONN_ID_WIDTH-1:0]            rd_conn_id
);

    logic [ROUTING_TABLE_WORD_WIDTH-1:0] words [TABLE_WORDS];
    logic [ROUTING_TABLE_WORD_BITS-1:0]  rd_word;
    logic [LANE_BITS-1:0]                rd_lane;
    logic [LSB_BITS-1:0]                 rd_lsb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TABLE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_addr] <= wr_data;
        end
    end

    assign rd_word = rd_entry[ENTRY_BITS-1 -: ROUTING_TABLE_WORD_BITS];
    assign rd_lane = rd_entry[LANE_BITS-1:0];
    assign rd_lsb  = LSB_BITS'(rd_lane) * LSB_BITS'(CONN_ID_WIDTH);

    always_comb begin
        rd_conn_id = words[rd_word][rd_lsb +: CONN_ID_WIDTH];
    end

endmodule

// File: rtl/route_table_lookup.sv
// Routing-table lookup: load FSM, 2-stage valid/ready pipeline.
// Define ROUTE_LOOKUP_STATS_EN for saturating lookup/miss counters.
module route_table_lookup
    import route_table_lookup_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                routing_table_program_en,
    input  logic [ROUTING_TABLE_WORD_BITS-1:0]  routing_table_word_addr,
    input  logic [ROUTING_TABLE_WORD_WIDTH-1:0] routing_table_word,
    input  logic                                network_layer_program_en,
    input  logic [DEVICE_ID_WIDTH-1:0]          device_id,
    output logic                                table_ready,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [DEVICE_ID_WIDTH-1:0]          req_dest_id,
    input  logic [TAG_WIDTH-1:0]                req_tag,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [CONN_ID_WIDTH-1:0]            rsp_conn_id,
    output logic                                rsp_local,
    output logic                                rsp_miss,
    output logic [TAG_WIDTH-1:0]                rsp_tag
`ifdef ROUTE_LOOKUP_STATS_EN
   ,output logic [31:0]                         lookup_count,
    output logic [31:0]                         miss_count
`endif
);

    rtl_state_t               state_q;
    rtl_state_t               state_d;
    lookup_t                  lookup_d;
    lookup_t                  s1_q;
    lookup_t                  s2_q;
    logic                     s1_valid;
    logic                     s2_valid;
    logic                     s2_ready;
    logic                     s1_adv;
    logic                     accept;
    logic [CONN_ID_WIDTH-1:0] entry_conn;

    route_table_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (routing_table_program_en),
        .wr_addr    (routing_table_word_addr),
        .wr_data    (routing_table_word),
        .rd_entry   (req_dest_id[ENTRY_BITS-1:0]),
        .rd_conn_id (entry_conn)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (routing_table_program_en) state_d = LOADING;
            LOADING: if (network_layer_program_en) state_d = ARMED;
            ARMED:   if (routing_table_program_en) state_d = LOADING;
            default: state_d = EMPTY;
        endcase
    end

    assign table_ready = (state_q == ARMED);

    // A programming cycle blocks accepts so no lookup races a write.
    assign s2_ready  = ~s2_valid | rsp_ready;
    assign s1_adv    = s1_valid & s2_ready;
    assign req_ready = table_ready & ~routing_table_program_en
                     & (~s1_valid | s2_ready);
    assign accept    = req_valid & req_ready;

    assign lookup_d = resolve(req_dest_id, device_id, entry_conn, req_tag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_q     <= lookup_d;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s1_q;
            end
        end
    end

    assign rsp_valid   = s2_valid;
    assign rsp_conn_id = s2_q.conn_id;
    assign rsp_local   = s2_q.is_local;
    assign rsp_miss    = s2_q.miss;
    assign rsp_tag     = s2_q.tag;

`ifdef ROUTE_LOOKUP_STATS_EN
    logic arm_entry;
    logic rsp_fire;

    assign arm_entry = (state_q != ARMED) & (state_d == ARMED);
    assign rsp_fire  = s2_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || arm_entry) begin
            lookup_count <= '0;
            miss_count   <= '0;
        end else if (rsp_fire) begin
            if (lookup_count != '1) begin
                lookup_count <= lookup_count + 32'd1;
            end
            if (s2_q.miss && (miss_count != '1)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_route_table_lookup.sv
// Randomized bench for route_table_lookup against a behavioural model.
// Stats checks are active when ROUTE_LOOKUP_STATS_EN is defined.
module tb_route_table_lookup;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pe;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic        nlpe;
    logic [9:0]  device_id;
    logic        table_ready;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_dest_id;
    logic [7:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_conn_id;
    logic        rsp_local;
    logic        rsp_miss;
    logic [7:0]  rsp_tag;
    logic [31:0] lookup_count;
    logic [31:0] miss_count;

    route_table_lookup dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .routing_table_program_en (pe),
        .routing_table_word_addr  (waddr),
        .routing_table_word       (wdata),
        .network_layer_program_en (nlpe),
        .device_id                (device_id),
        .table_ready              (table_ready),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_dest_id              (req_dest_id),
        .req_tag                  (req_tag),
        .rsp_valid                (rsp_valid),
        .rsp_ready                (rsp_ready),
        .rsp_conn_id              (rsp_conn_id),
        .rsp_local                (rsp_local),
        .rsp_miss                 (rsp_miss),
        .rsp_tag                  (rsp_tag)
`ifdef ROUTE_LOOKUP_STATS_EN
       ,.lookup_count             (lookup_count),
        .miss_count               (miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] conn;
        logic       loc;
        logic       miss;
        logic [7:0] tag;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   rsp_mode = 0;
    int   n_pops = 0;
    exp_t last_pop;

    logic [3:0] mtab [32];
    exp_t       q [$];
    int         m_state = 0;
    int         m_lc = 0;
    int         m_mc = 0;
    bit         stall_prev = 0;
    exp_t       stall_val;

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t predict(input logic [9:0] dest,
                                     input logic [9:0] dev,
                                     input logic [7:0] tag);
        exp_t e;
        e = '0;
        e.tag = tag;
        if (dest == dev) e.loc = 1'b1;
        else if (int'(dest) >= 32) e.miss = 1'b1;
        else e.conn = mtab[dest];
        return e;
    endfunction

    // Model states: 0 empty, 1 loading, 2 armed.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        bit   exp_rr;
        got = {rsp_conn_id, rsp_local, rsp_miss, rsp_tag};
        if (!rst_n) begin
            q.delete();
            foreach (mtab[i]) mtab[i] = '0;
            m_state = 0;
            m_lc = 0;
            m_mc = 0;
            stall_prev = 0;
        end else begin
            chk(table_ready == (m_state == 2), "table_ready",
                table_ready, m_state == 2);
            exp_rr = (m_state == 2) && !pe
                   && (q.size() < 2 || rsp_ready);
            chk(req_ready == exp_rr, "req_ready", req_ready, exp_rr);
            if (stall_prev) begin
                chk(rsp_valid && got == stall_val, "rsp_hold",
                    {rsp_valid, got}, {1'b1, stall_val});
            end
`ifdef ROUTE_LOOKUP_STATS_EN
            chk(lookup_count == m_lc, "lookup_count", lookup_count, m_lc);
            chk(miss_count == m_mc, "miss_count", miss_count, m_mc);
`endif
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk(0, "rsp_spurious", got, 0);
                end else if (rsp_ready) begin
                    e = q.pop_front();
                    chk(got == e, "rsp_data", got, e);
                    last_pop = got;
                    n_pops++;
                    m_lc++;
                    if (e.miss) m_mc++;
                end
            end
            stall_prev = rsp_valid && !rsp_ready;
            stall_val  = got;
            if (req_valid && exp_rr) begin
                q.push_back(predict(req_dest_id, device_id, req_tag));
            end
            if (pe) begin
                for (int k = 0; k < 8; k++) begin
                    mtab[waddr*8 + k] = wdata[4*k +: 4];
                end
            end
            if (m_state == 1 && nlpe) begin
                m_state = 2;
                m_lc = 0;
                m_mc = 0;
            end else if (pe) begin
                m_state = 1;
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = ~rsp_ready;
                2: rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [1:0] a, input logic [31:0] d);
        pe = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        pe = 1'b0;
    endtask

    task automatic arm();
        nlpe = 1'b1;
        tick();
        nlpe = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) chk(0, "req_ready_timeout", 0, 1);
    endtask

    task automatic lookup(input logic [9:0] dest, input logic [7:0] tag,
                          input logic [3:0] c, input bit l, input bit m);
        int n;
        req_valid = 1'b1;
        req_dest_id = dest;
        req_tag = tag;
        wait_ready();
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk(rsp_valid && rsp_conn_id == c && rsp_local == l
            && rsp_miss == m && rsp_tag == tag, "lookup_literal",
            {rsp_valid, rsp_conn_id, rsp_local, rsp_miss, rsp_tag},
            {1'b1, c, l, m, tag});
        tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(q.size() == 0, "drain", q.size(), 0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        pe = 1'b0;
        waddr = '0;
        wdata = '0;
        nlpe = 1'b0;
        device_id = 10'd5;
        req_valid = 1'b0;
        req_dest_id = '0;
        req_tag = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk(!rsp_valid && !table_ready && !req_ready && rsp_conn_id == 0
            && rsp_tag == 0 && !rsp_local && !rsp_miss, "reset_outputs",
            {rsp_valid, table_ready, req_ready}, 0);

        // Unprogrammed: arm pulse ignored, requests never accepted.
        arm();
        req_valid = 1'b1;
        req_dest_id = 10'd9;
        for (int i = 0; i < 20; i++) begin
            chk(!req_ready && !rsp_valid, "empty_blocks",
                {req_ready, rsp_valid}, 0);
            tick();
        end
        req_valid = 1'b0;
        chk(!table_ready, "empty_not_armed", table_ready, 0);

        write_word(2'd0, 32'h76543210);
        write_word(2'd1, 32'hFEDCBA98);
        write_word(2'd2, 32'h0);
        write_word(2'd3, 32'h0);
        tick();
        arm();
        chk(table_ready, "armed", table_ready, 1);

        req_valid = 1'b1;
        req_dest_id = 10'd9;
        req_tag = 8'hA1;
        chk(req_ready, "t1_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk(!rsp_valid, "t1_lat1", rsp_valid, 0);
        tick();
        chk(rsp_valid && rsp_conn_id == 4'h9 && !rsp_local && !rsp_miss
            && rsp_tag == 8'hA1, "t1_lat2",
            {rsp_valid, rsp_conn_id, rsp_tag}, {1'b1, 4'h9, 8'hA1});
        tick();

        lookup(10'd5, 8'h22, 4'h0, 1'b1, 1'b0);
        lookup(10'd40, 8'h33, 4'h0, 1'b0, 1'b1);
        lookup(10'd15, 8'h34, 4'hF, 1'b0, 1'b0);
        lookup(10'd31, 8'h35, 4'h0, 1'b0, 1'b0);
        lookup(10'd32, 8'h36, 4'h0, 1'b0, 1'b1);
        lookup(10'd1023, 8'h37, 4'h0, 1'b0, 1'b1);
        device_id = 10'd40;
        lookup(10'd40, 8'h38, 4'h0, 1'b1, 1'b0);
        device_id = 10'd5;

        // Back-to-back with toggling response backpressure.
        rsp_mode = 1;
        base = n_pops;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            req_dest_id = 10'(i);
            req_tag = 8'(i);
            wait_ready();
            tick();
        end
        req_valid = 1'b0;
        wait_drain();
        chk(n_pops - base == 16, "t3_count", n_pops - base, 16);
        chk(last_pop.tag == 8'd15, "t3_last_tag", last_pop.tag, 15);

        // Reprogram while lookups are in flight.
        rsp_mode = 3;
        tick();
        req_valid = 1'b1;
        req_dest_id = 10'd3;
        req_tag = 8'h40;
        wait_ready();
        tick();
        req_tag = 8'h41;
        wait_ready();
        tick();
        req_valid = 1'b0;
        pe = 1'b1;
        waddr = 2'd0;
        wdata = 32'h0;
        chk(!req_ready, "t4_ready_during_pe", req_ready, 0);
        tick();
        pe = 1'b0;
        chk(!table_ready && !req_ready, "t4_disarmed",
            {table_ready, req_ready}, 0);
        rsp_mode = 0;
        req_valid = 1'b1;
        repeat (5) tick();
        req_valid = 1'b0;
        wait_drain();
        chk(last_pop.conn == 4'h3 && last_pop.tag == 8'h41, "t4_old_conn",
            {last_pop.conn, last_pop.tag}, {4'h3, 8'h41});
        arm();
        lookup(10'd3, 8'h42, 4'h0, 1'b0, 1'b0);

`ifdef ROUTE_LOOKUP_STATS_EN
        write_word(2'd2, 32'h11111111);
        arm();
        chk(lookup_count == 0 && miss_count == 0, "t6_cleared",
            {lookup_count, miss_count}, 0);
        for (int i = 0; i < 7; i++) begin
            lookup(10'(8 + i), 8'(i), 4'(8 + i), 1'b0, 1'b0);
        end
        lookup(10'd40, 8'h50, 4'h0, 1'b0, 1'b1);
        lookup(10'd50, 8'h51, 4'h0, 1'b0, 1'b1);
        lookup(10'd33, 8'h52, 4'h0, 1'b0, 1'b1);
        chk(lookup_count == 10 && miss_count == 3, "t6_counts",
            {lookup_count, miss_count}, {32'd10, 32'd3});
        write_word(2'd2, 32'h0);
        arm();
        chk(lookup_count == 0 && miss_count == 0, "t6_rearm_clear",
            {lookup_count, miss_count}, 0);
`endif

        // Reset with lookups in flight drops them.
        rsp_mode = 3;
        req_valid = 1'b1;
        req_dest_id = 10'd9;
        wait_ready();
        tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rsp_mode = 0;
        tick();
        chk(!rsp_valid && !table_ready, "reset_drop",
            {rsp_valid, table_ready}, 0);
        repeat (4) tick();

        // Randomized traffic with occasional reprogramming.
        for (int w = 0; w < 4; w++) write_word(2'(w), $urandom);
        arm();
        rsp_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_dest_id = 10'($urandom_range(0, 47));
            if ($urandom_range(0, 15) == 0) req_dest_id = device_id;
            req_tag = 8'($urandom);
            pe = ($urandom_range(0, 149) == 0);
            waddr = 2'($urandom);
            wdata = $urandom;
            nlpe = !pe && ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) device_id = 10'($urandom_range(0, 40));
            tick();
        end
        req_valid = 1'b0;
        pe = 1'b0;
        nlpe = 1'b0;
        rsp_mode = 0;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
